mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning width of the memory-controller byte address.
REQ-002 SHALL have port clk  input  1  system clock, single clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high (asserted = `RstEnable).
REQ-004 SHALL have ports wd_i/wreg_i/wdata_i  input  5/1/32  destination reg, write-enable, ALU result or store data, from EX/MEM register.
REQ-005 SHALL have ports memaddr_i/memwr_i/memcnf_i/memsigned_i  input  32/1/2/1  address, 0=load 1=store, 0=none 1=B 2=H 3=W, load sign-extend.
REQ-006 SHALL have ports wd_o/wreg_o/wdata_o  output  5/1/32  writeback info to MEM/WB register and forwarding.
REQ-007 SHALL have port mem_stall  output  1  holds all upstream pipeline registers and PC.
REQ-008 SHALL have ports mem_req_o/mem_wr_o/mem_addr_o/mem_dout_o  output  1/1/ADDR_W/8  byte request to memory controller.
REQ-009 SHALL have ports mem_gnt_i/mem_din_i  input  1/8  grant; read byte.

Function
REQ-010 SHALL, when memcnf_i==0 and FSM in IDLE, pass wd/wreg/wdata through combinationally (0 latency), mem_stall=0.
REQ-011 SHALL implement FSM IDLE, ACCESS, LAST, DONE.
REQ-012 SHALL, in IDLE with memcnf_i!=0, assert mem_stall combinationally in the same cycle, latch address, data, wr, cnf, signed, wd, wreg, clear byte counter, go ACCESS.
REQ-013 SHALL set byte count N = 1/2/4 for cnf 1/2/3; byte k at address base+k (little-endian), address truncated to ADDR_W.
REQ-014 SHALL, in ACCESS, drive mem_req_o=1, mem_addr_o=base+cnt, mem_wr_o=latched wr, mem_dout_o=store byte cnt; increment cnt only in cycles with mem_gnt_i=1.
REQ-015 SHALL hold request fields stable while mem_req_o=1 and mem_gnt_i=0.
REQ-016 SHALL treat read byte for a grant at cycle t as valid on mem_din_i at t+1, captured into byte slot of that grant.
REQ-017 SHALL, on grant of byte N-1: store -> DONE; load -> LAST. LAST: capture final byte, mem_req_o=0, go DONE.
REQ-018 SHALL pipeline loads: new byte request may be granted in the same cycle a previous byte's data is captured.
REQ-019 SHALL, in DONE, drop mem_stall, present wdata_o = assembled load value (zero-/sign-extended from bit 7/15 per memsigned) or latched wdata for stores, wreg_o = latched wreg; return IDLE unconditionally next cycle, ignoring inputs during DONE.
REQ-020 SHALL force wreg_o=0 whenever mem_stall=1.
REQ-021 SHALL treat memsigned for cnf=3 as don't-care.

Reset
REQ-022 SHALL, while rst=1, drive all outputs 0 combinationally and enter IDLE at the next edge.
REQ-023 SHALL abort any in-flight access on reset; partial stores are not rolled back.

Configuration
REQ-024 SHALL, with MEM_ALIGN_CHECK_EN defined, detect H at odd address or W with address[1:0]!=0, skip memory access (no mem_req_o), go directly DONE, output wreg_o=0, and drive extra output misalign_o 1 bit high for that DONE cycle.
REQ-025 SHALL, without MEM_ALIGN_CHECK_EN, omit misalign_o and perform misaligned accesses byte-wise normally.

Structure
REQ-026 SHALL place FSM state encodings and memcnf codes (NONE/B/H/W) in the shared defines file alongside existing `SEL_* and bus widths.
REQ-027 SHALL contain one sub-module, mem_ext, combinational byte-assembly plus sign/zero extension.

Verification
REQ-028 SHALL cover: non-mem op wdata_i=0x1234, wreg_i=1 -> same-cycle wdata_o=0x1234, mem_stall=0.
REQ-029 SHALL cover: LW 0x100, gnt always 1, bytes 78,56,34,12 -> 4 req cycles, LAST, DONE wdata_o=0x12345678, stall 5 cycles.
REQ-030 SHALL cover: LB signed byte 0x80 -> 0xFFFFFF80; LBU same -> 0x00000080; LH 0x8001 -> 0xFFFF8001.
REQ-031 SHALL cover: SH 0x204 data 0xBEEF, gnt low 2 cycles per byte -> writes EF@0x204, BE@0x205, fields stable while waiting.
REQ-032 SHALL cover: rst asserted during 2nd byte of SW -> mem_req_o=0 same cycle, IDLE after edge, next LW runs correctly; with MEM_ALIGN_CHECK_EN, LW 0x102 -> no request, misalign_o=1, wreg_o=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the memory stage.
//   Widths of the register index and data path, reset level, FSM state
//   encodings, memory-access size codes (memcnf) and the latched request
//   record used while an access is in flight.
package mem_stage_pkg;

   localparam int   DATA_W     = 32;
   localparam int   REG_IDX_W  = 5;
   localparam int   BYTE_W     = 8;
   localparam logic RST_ENABLE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_LAST   = 2'd2,
      ST_DONE   = 2'd3
   } mem_state_e;

   typedef enum logic [1:0] {
      CNF_NONE = 2'd0,
      CNF_B    = 2'd1,
      CNF_H    = 2'd2,
      CNF_W    = 2'd3
   } mem_cnf_e;

   typedef struct packed {
      logic [DATA_W-1:0]    data;
      logic                 wr;
      logic [1:0]           cnf;
      logic                 sgn;
      logic [REG_IDX_W-1:0] wd;
      logic                 wreg;
   } mem_req_t;

   // Index of the final byte of an access (N-1 for N = 1/2/4).
   function automatic logic [1:0] last_byte_idx(input logic [1:0] cnf);
      case (cnf)
         CNF_H:   return 2'd1;
         CNF_W:   return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_ext.sv
// mem_ext -- load-value extension.
//   Takes the little-endian assembled load bytes and produces the 32-bit
//   writeback value, zero- or sign-extending from bit 7 (byte) or bit 15
//   (half). Word loads pass through; the sign flag is ignored for them.
// Ports:
//   raw_bytes  in  32  assembled bytes, byte k in bits [8k+7:8k]
//   cnf        in  2   access size code
//   sign_en    in  1   sign-extend narrow loads
//   ext_data   out 32  extended load value
module mem_ext
   import mem_stage_pkg::*;
(
   input  logic [DATA_W-1:0] raw_bytes,
   input  logic [1:0]        cnf,
   input  logic              sign_en,
   output logic [DATA_W-1:0] ext_data
);

   always_comb begin
      ext_data = '0;
      case (cnf)
         CNF_B:   ext_data = {{24{sign_en & raw_bytes[7]}},  raw_bytes[7:0]};
         CNF_H:   ext_data = {{16{sign_en & raw_bytes[15]}}, raw_bytes[15:0]};
         CNF_W:   ext_data = raw_bytes;
         default: ext_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory stage with a byte-serial memory port.
//   Non-memory ops pass straight through with zero latency. Loads and stores
//   of 1/2/4 bytes are split into byte requests at base+k (little-endian) to
//   the memory controller while the upstream pipeline is stalled. Load bytes
//   arrive the cycle after their grant; requests are pipelined so a new byte
//   may be granted while the previous one is captured.
//   Optional build macro MEM_ALIGN_CHECK_EN: misaligned H/W accesses skip
//   memory entirely, finish with wreg_o=0 and flag misalign_o.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wd_i/wreg_i/wdata_i            dest reg, write enable, ALU result/store data
//   memaddr_i/memwr_i/memcnf_i/memsigned_i  address, store, size, sign-extend
//   wd_o/wreg_o/wdata_o            writeback to MEM/WB and forwarding
//   mem_stall                      freezes upstream pipeline registers and PC
//   misalign_o                     (MEM_ALIGN_CHECK_EN only) misaligned access
//   mem_req_o/mem_wr_o/mem_addr_o/mem_dout_o  byte request to controller
//   mem_gnt_i/mem_din_i            grant, read byte (valid cycle after grant)
//
// state   | meaning
// IDLE    | pass-through; a mem op latches its request and stalls
// ACCESS  | issuing byte requests, byte counter advances on grant
// LAST    | load only: capture final byte, no request
// DONE    | stall released, result presented for one cycle
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] wd_i,
   input  logic                 wreg_i,
   input  logic [DATA_W-1:0]    wdata_i,
   input  logic [31:0]          memaddr_i,
   input  logic                 memwr_i,
   input  logic [1:0]           memcnf_i,
   input  logic                 memsigned_i,
   output logic [REG_IDX_W-1:0] wd_o,
   output logic                 wreg_o,
   output logic [DATA_W-1:0]    wdata_o,
   output logic                 mem_stall,
`ifdef MEM_ALIGN_CHECK_EN
   output logic                 misalign_o,
`endif
   output logic                 mem_req_o,
   output logic                 mem_wr_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [BYTE_W-1:0]    mem_dout_o,
   input  logic                 mem_gnt_i,
   input  logic [BYTE_W-1:0]    mem_din_i
);

   mem_state_e        state_q, state_d;
   mem_req_t          req_q;
   logic [ADDR_W-1:0] base_q;
   logic [1:0]        cnt_q;
   logic              cap_vld_q;
   logic [1:0]        cap_slot_q;
   logic [DATA_W-1:0] bytes_q;
   logic [DATA_W-1:0] load_data;
   logic              start_op;
   logic              mis_now;
   logic              mis_done;
   logic              last_gnt;

   assign start_op = (memcnf_i != CNF_NONE);
   assign last_gnt = mem_gnt_i && (cnt_q == last_byte_idx(req_q.cnf));

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign_q;

   assign mis_now  = ((memcnf_i == CNF_H) && memaddr_i[0]) ||
                     ((memcnf_i == CNF_W) && (memaddr_i[1:0] != 2'b00));
   assign mis_done = misalign_q;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         misalign_q <= 1'b0;
      end else if (state_q == ST_IDLE && start_op) begin
         misalign_q <= mis_now;
      end
   end
`else
   assign mis_now  = 1'b0;
   assign mis_done = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_op) begin
               state_d = mis_now ? ST_DONE : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (last_gnt) begin
               state_d = req_q.wr ? ST_DONE : ST_LAST;
            end
         end
         ST_LAST: state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Request latch, byte counter and load-byte capture. A grant schedules a
   // capture of mem_din_i into that grant's slot on the following cycle, so
   // the final load byte lands during LAST and is ready by DONE.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         req_q      <= '0;
         base_q     <= '0;
         cnt_q      <= '0;
         cap_vld_q  <= 1'b0;
         cap_slot_q <= '0;
         bytes_q    <= '0;
      end else begin
         cap_vld_q <= 1'b0;
         if (state_q == ST_IDLE && start_op) begin
            req_q.data <= wdata_i;
            req_q.wr   <= memwr_i;
            req_q.cnf  <= memcnf_i;
            req_q.sgn  <= memsigned_i;
            req_q.wd   <= wd_i;
            req_q.wreg <= wreg_i;
            base_q     <= ADDR_W'(memaddr_i);
            cnt_q      <= '0;
         end
         if (state_q == ST_ACCESS && mem_gnt_i) begin
            cnt_q      <= cnt_q + 2'd1;
            cap_vld_q  <= ~req_q.wr;
            cap_slot_q <= cnt_q;
         end
         if (cap_vld_q) begin
            bytes_q[{cap_slot_q, 3'b000} +: BYTE_W] <= mem_din_i;
         end
      end
   end

   mem_ext u_mem_ext (
      .raw_bytes (bytes_q),
      .cnf       (req_q.cnf),
      .sign_en   (req_q.sgn),
      .ext_data  (load_data)
   );

   always_comb begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      mem_stall  = 1'b0;
      mem_req_o  = 1'b0;
      mem_wr_o   = 1'b0;
      mem_addr_o = '0;
      mem_dout_o = '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o = 1'b0;
`endif
      if (rst != RST_ENABLE) begin
         case (state_q)
            ST_IDLE: begin
               wd_o    = wd_i;
               wdata_o = wdata_i;
               if (start_op) begin
                  mem_stall = 1'b1;
               end else begin
                  wreg_o = wreg_i;
               end
            end
            ST_ACCESS: begin
               wd_o       = req_q.wd;
               mem_stall  = 1'b1;
               mem_req_o  = 1'b1;
               mem_wr_o   = req_q.wr;
               mem_addr_o = base_q + ADDR_W'(cnt_q);
               mem_dout_o = req_q.data[{cnt_q, 3'b000} +: BYTE_W];
            end
            ST_LAST: begin
               wd_o      = req_q.wd;
               mem_stall = 1'b1;
            end
            ST_DONE: begin
               wd_o    = req_q.wd;
               wreg_o  = req_q.wreg & ~mis_done;
               wdata_o = req_q.wr ? req_q.data : load_data;
`ifdef MEM_ALIGN_CHECK_EN
               misalign_o = misalign_q;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [31:0] memaddr_i;
   logic        memwr_i;
   logic [1:0]  memcnf_i;
   logic        memsigned_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        mem_stall;
   logic        misalign_o;
   logic        mem_req_o;
   logic        mem_wr_o;
   logic [31:0] mem_addr_o;
   logic [7:0]  mem_dout_o;
   logic        mem_gnt_i;
   logic [7:0]  mem_din_i;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
   assign misalign_o = 1'b0;
`endif

   mem_stage #(.ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .wd_i        (wd_i),
      .wreg_i      (wreg_i),
      .wdata_i     (wdata_i),
      .memaddr_i   (memaddr_i),
      .memwr_i     (memwr_i),
      .memcnf_i    (memcnf_i),
      .memsigned_i (memsigned_i),
      .wd_o        (wd_o),
      .wreg_o      (wreg_o),
      .wdata_o     (wdata_o),
      .mem_stall   (mem_stall),
`ifdef MEM_ALIGN_CHECK_EN
      .misalign_o  (misalign_o),
`endif
      .mem_req_o   (mem_req_o),
      .mem_wr_o    (mem_wr_o),
      .mem_addr_o  (mem_addr_o),
      .mem_dout_o  (mem_dout_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_din_i   (mem_din_i)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] mem [0:4095];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   function automatic bit is_mis(input logic [1:0] cnf, input logic [31:0] a);
      return ALIGN_EN && ((cnf == 2'd2 && a[0]) || (cnf == 2'd3 && a[1:0] != 2'b00));
   endfunction

   // Reference result: pass-through / store data, or the load value built
   // from the byte memory and extended arithmetically.
   function automatic logic [31:0] model_val(input logic [1:0] cnf, input logic wr,
                                             input logic sgn, input logic [31:0] a,
                                             input logic [31:0] d);
      int unsigned n, v;
      if (cnf == 2'd0 || wr) return d;
      n = 1 << (cnf - 1);
      v = 0;
      for (int k = 0; k < 4; k++)
         if (k < int'(n)) v = v + (int'(mem[12'(a + k)]) << (8 * k));
      if (sgn && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
      return v;
   endfunction

   // Applies one op from IDLE, acts as the memory controller until the stall
   // drops, then checks the DONE cycle and the request/grant trace.
   task automatic run_op(input string nm, input logic [1:0] cnf, input logic wr,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] wd, input logic wreg, input int wait_cyc,
                         input bit rnd_gnt, input logic [31:0] exp_wdata, input int exp_stall);
      int n, stall_cnt, req_cnt, wait_ctr, unstable, wreg_bad;
      bit mis, pend, waiting, finished, grant;
      logic [31:0] pend_addr, prev_addr, got_wdata;
      logic prev_wr, got_wreg, got_mis;
      logic [7:0] prev_dout;
      logic [4:0] got_wd;
      logic [31:0] gnt_addr[$];
      logic [7:0]  gnt_byte[$];
      n = (cnf == 2'd0) ? 0 : (1 << (cnf - 1));
      mis = is_mis(cnf, addr);
      if (mis) n = 0;
      stall_cnt = 0; req_cnt = 0; wait_ctr = 0; unstable = 0; wreg_bad = 0;
      pend = 0; waiting = 0; finished = 0;
      pend_addr = '0; prev_addr = '0; prev_wr = 0; prev_dout = '0;
      got_wdata = '0; got_wreg = 0; got_wd = '0; got_mis = 0;
      @(posedge clk); #1;
      memcnf_i = cnf; memwr_i = wr; memsigned_i = sgn; memaddr_i = addr;
      wdata_i = data; wd_i = wd; wreg_i = wreg; mem_gnt_i = 0; mem_din_i = 8'($urandom);
      #1;
      chk({nm, " stall_decode"}, mem_stall, cnf != 2'd0);
      if (cnf == 2'd0) begin
         chk({nm, " pass_wdata"}, wdata_o, exp_wdata);
         chk({nm, " pass_wreg"}, wreg_o, wreg);
         chk({nm, " pass_wd"}, wd_o, wd);
         return;
      end
      chk({nm, " decode_req"}, {wreg_o, mem_req_o}, 0);
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(posedge clk); #1;
         mem_din_i = pend ? mem[pend_addr[11:0]] : 8'($urandom);
         pend = 0; mem_gnt_i = 0;
         #1;
         if (!mem_stall) begin
            finished = 1; got_wdata = wdata_o; got_wreg = wreg_o; got_wd = wd_o;
            got_mis = misalign_o;
            if (mem_req_o) unstable++;
            break;
         end
         stall_cnt++;
         if (wreg_o) wreg_bad++;
         if (mem_req_o) begin
            req_cnt++;
            if (waiting && (mem_addr_o !== prev_addr || mem_wr_o !== prev_wr ||
                            mem_dout_o !== prev_dout)) unstable++;
            grant = rnd_gnt ? ($urandom_range(0, 2) != 0) : (wait_ctr == wait_cyc);
            if (grant) begin
               wait_ctr = 0; waiting = 0;
               gnt_addr.push_back(mem_addr_o);
               if (mem_wr_o) begin
                  gnt_byte.push_back(mem_dout_o);
                  mem[mem_addr_o[11:0]] = mem_dout_o;
               end else begin
                  pend = 1; pend_addr = mem_addr_o;
               end
               mem_gnt_i = 1;
            end else begin
               wait_ctr++; waiting = 1;
               prev_addr = mem_addr_o; prev_wr = mem_wr_o; prev_dout = mem_dout_o;
            end
         end
      end
      chk({nm, " finished"}, finished, 1);
      chk({nm, " wd"}, got_wd, wd);
      chk({nm, " wreg"}, got_wreg, mis ? 1'b0 : wreg);
      if (!mis) chk({nm, " wdata"}, got_wdata, exp_wdata);
      if (ALIGN_EN) chk({nm, " misalign"}, got_mis, mis);
      chk({nm, " n_grants"}, gnt_addr.size(), n);
      for (int k = 0; k < gnt_addr.size() && k < n; k++) begin
         chk({nm, " gnt_addr"}, gnt_addr[k], addr + k);
         if (wr) chk({nm, " store_byte"}, gnt_byte[k], (data >> (8 * k)) & 32'hFF);
      end
      chk({nm, " stable_and_idle"}, unstable, 0);
      chk({nm, " wreg_in_stall"}, wreg_bad, 0);
      if (!rnd_gnt) chk({nm, " req_cycles"}, req_cnt, n * (wait_cyc + 1));
      if (exp_stall >= 0) chk({nm, " stall_cycles"}, stall_cnt, exp_stall);
      else if (mis) chk({nm, " stall_cycles"}, stall_cnt, 0);
   endtask

   typedef struct {
      string       nm;
      logic [1:0]  cnf;
      logic        wr;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  wd;
      logic        wreg;
      int          wait_cyc;
      logic [31:0] exp_wdata;
      int          exp_stall;
   } vec_t;

   initial begin
      vec_t tbl[$];
      logic [1:0] r_cnf;
      logic r_wr, r_sgn, r_wreg;
      logic [31:0] r_addr, r_data;
      logic [4:0] r_wd;

      tbl.push_back('{"nonmem", 2'd0, 1'b0, 1'b0, 32'h0,   32'h1234,     5'd3,  1'b1, 0, 32'h1234,     0});
      tbl.push_back('{"lw",     2'd3, 1'b0, 1'b0, 32'h100, 32'h0,        5'd5,  1'b1, 0, 32'h12345678, 5});
      tbl.push_back('{"lb",     2'd1, 1'b0, 1'b1, 32'h110, 32'h0,        5'd6,  1'b1, 0, 32'hFFFFFF80, 2});
      tbl.push_back('{"lbu",    2'd1, 1'b0, 1'b0, 32'h110, 32'h0,        5'd7,  1'b1, 0, 32'h00000080, 2});
      tbl.push_back('{"lh",     2'd2, 1'b0, 1'b1, 32'h120, 32'h0,        5'd8,  1'b1, 0, 32'hFFFF8001, 3});
      tbl.push_back('{"lhu_w1", 2'd2, 1'b0, 1'b0, 32'h120, 32'h0,        5'd9,  1'b1, 1, 32'h00008001, 5});
      tbl.push_back('{"sh_w2",  2'd2, 1'b1, 1'b0, 32'h204, 32'hBEEF,     5'd0,  1'b0, 2, 32'hBEEF,     6});
      tbl.push_back('{"sw",     2'd3, 1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 5'd0,  1'b0, 0, 32'hCAFEF00D, 4});
`ifndef MEM_ALIGN_CHECK_EN
      tbl.push_back('{"lw_odd", 2'd3, 1'b0, 1'b0, 32'h101, 32'h0,        5'd10, 1'b1, 0, 32'hAB123456, 5});
`endif

      for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
      mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
      mem[12'h104] = 8'hAB; mem[12'h110] = 8'h80; mem[12'h120] = 8'h01; mem[12'h121] = 8'h80;

      rst = 1'b1; memcnf_i = 2'd3; memwr_i = 1'b1; memsigned_i = 1'b1;
      memaddr_i = 32'h100; wdata_i = 32'hDEADBEEF; wd_i = 5'h1F; wreg_i = 1'b1;
      mem_gnt_i = 1'b1; mem_din_i = 8'hFF;
      @(posedge clk); #1; @(posedge clk); #2;
      chk("rst_ctrl", {mem_stall, mem_req_o, mem_wr_o, wreg_o, misalign_o}, 0);
      chk("rst_wd", wd_o, 0);
      chk("rst_wdata", wdata_o, 0);
      chk("rst_addr_dout", {mem_addr_o, mem_dout_o}, 0);
      @(posedge clk); #1;
      rst = 1'b0; memcnf_i = 2'd0; mem_gnt_i = 1'b0;

      foreach (tbl[i])
         run_op(tbl[i].nm, tbl[i].cnf, tbl[i].wr, tbl[i].sgn, tbl[i].addr, tbl[i].data,
                tbl[i].wd, tbl[i].wreg, tbl[i].wait_cyc, 1'b0, tbl[i].exp_wdata,
                tbl[i].exp_stall);
      chk("sh_mem_ef", mem[12'h204], 32'hEF);
      chk("sh_mem_be", mem[12'h205], 32'hBE);

      // Reset during the second byte of a word store.
      @(posedge clk); #1;
      memcnf_i = 2'd3; memwr_i = 1'b1; memaddr_i = 32'h400; wdata_i = 32'h11223344;
      wreg_i = 1'b0; wd_i = 5'd0; mem_gnt_i = 1'b0;
      @(posedge clk); #2;
      chk("sw_rst_b0_addr", mem_addr_o, 32'h400);
      chk("sw_rst_b0_dout", mem_dout_o, 32'h44);
      mem[12'h400] = mem_dout_o; mem_gnt_i = 1'b1;
      @(posedge clk); #1;
      mem_gnt_i = 1'b0;
      #1;
      chk("sw_rst_b1_req", mem_req_o, 1);
      rst = 1'b1;
      #1;
      chk("sw_rst_req_drop", {mem_req_o, mem_stall}, 0);
      @(posedge clk); #1;
      rst = 1'b0; memcnf_i = 2'd0; wreg_i = 1'b1; wdata_i = 32'h55; wd_i = 5'd4;
      #1;
      chk("post_rst_idle", {mem_stall, mem_req_o, wreg_o}, 32'b001);
      chk("post_rst_wdata", wdata_o, 32'h55);
      run_op("lw_after_rst", 2'd3, 1'b0, 1'b0, 32'h100, 32'h0, 5'd11, 1'b1, 0, 1'b0,
             32'h12345678, 5);
      chk("partial_store", mem[12'h400], 32'h44);

`ifdef MEM_ALIGN_CHECK_EN
      run_op("lw_mis", 2'd3, 1'b0, 1'b0, 32'h102, 32'h0, 5'd12, 1'b1, 0, 1'b0, 32'h0, 0);
      run_op("lh_mis", 2'd2, 1'b1, 1'b0, 32'h103, 32'h77, 5'd13, 1'b1, 0, 1'b0, 32'h0, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         r_cnf = 2'($urandom_range(0, 3)); r_wr = 1'($urandom); r_sgn = 1'($urandom);
         r_addr = 32'($urandom_range(0, 4000)); r_data = $urandom;
         r_wd = 5'($urandom); r_wreg = 1'($urandom);
         run_op("rnd", r_cnf, r_wr, r_sgn, r_addr, r_data, r_wd, r_wreg, 0, 1'b1,
                model_val(r_cnf, r_wr, r_sgn, r_addr, r_data), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

endmodule
